// File: rtl/edge_event_counter_if.sv
// edge_event_counter_if: valid/ready handshake carrying the counter snapshot
interface edge_event_counter_if #(parameter int CNT_W = 8);
    logic             cnt_vld;
    logic             cnt_rdy;
    logic [CNT_W-1:0] cnt_data;
    modport master (output cnt_vld, cnt_data, input cnt_rdy);
    modport slave (input cnt_vld, cnt_data, output cnt_rdy);
endinterface

// File: rtl/edge_event_counter.sv
// edge_event_counter: glitch-filtered level with edge pulses, saturating rise counter and snapshot handshake
module edge_event_counter #(
    parameter int FILT  = 3,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    input  logic snap,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ovf,
    edge_event_counter_if.master bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [3:0]       stab;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flip;
    logic             inc;
    logic             sat;
    always_comb begin
        flip    = (din != level) && (stab + 4'd1 == 4'(FILT));
        inc     = rise & en;
        sat     = &cnt;
        cnt_nxt = (inc && !sat) ? cnt + 1'b1 : cnt;
    end
    assign bus.cnt_vld = (state == HOLD);
    always_ff @(posedge clk) begin
        if (rst) begin
            level        <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            stab         <= 4'd0;
            cnt          <= '0;
            ovf          <= 1'b0;
            state        <= IDLE;
            bus.cnt_data <= '0;
        end else begin
            rise  <= flip & ~level;
            fall  <= flip & level;
            level <= level ^ flip;
            stab  <= (din == level || flip) ? 4'd0 : stab + 4'd1;
            // snapshot captures this cycle's increment, so the edge is never lost
            if (state == IDLE && snap) begin
                bus.cnt_data <= cnt_nxt;
                cnt          <= '0;
                ovf          <= 1'b0;
                state        <= HOLD;
            end else begin
                cnt <= cnt_nxt;
                ovf <= ovf | (inc & sat);
                if (state == HOLD && bus.cnt_rdy) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_edge_event_counter.sv
// tb_edge_event_counter: directed scenarios plus random stimulus against a window-based reference model
module tb_edge_event_counter;
    localparam int FILT = 3;
    logic clk = 1'b0;
    logic rst = 1'b1, din = 1'b0, en = 1'b0, snap = 1'b0, rdy = 1'b0;
    logic level, rise, fall, ovf, level2, rise2, fall2, ovf2;
    edge_event_counter_if #(.CNT_W(8)) b8();
    edge_event_counter_if #(.CNT_W(2)) b2();
    assign b8.cnt_rdy = rdy;
    assign b2.cnt_rdy = rdy;
    edge_event_counter #(.FILT(FILT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .snap(snap),
        .level(level), .rise(rise), .fall(fall), .ovf(ovf), .bus(b8));
    edge_event_counter #(.FILT(FILT), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .en(en), .snap(snap),
        .level(level2), .rise(rise2), .fall(fall2), .ovf(ovf2), .bus(b2));
    always #5 clk = ~clk;

    int   vectors = 0, miscompares = 0;
    logic m_lvl = 0, m_rise = 0, m_fall = 0, m_vld = 0;
    logic m_ovf[2] = '{0, 0};
    int   m_cnt[2] = '{0, 0}, m_data[2] = '{0, 0};
    int   mx[2] = '{255, 3};
    int   hist[$];

    // model: level flips once the last FILT samples all disagree with it
    task automatic step();
        logic inc, all, set;
        int c;
        @(posedge clk);
        if (rst) begin
            m_lvl = 0; m_rise = 0; m_fall = 0; m_vld = 0;
            hist.delete();
            for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; m_data[k] = 0; end
        end else begin
            inc = m_rise && en;
            hist.push_back(int'(din));
            if (hist.size() > FILT) void'(hist.pop_front());
            all = (hist.size() == FILT);
            foreach (hist[i]) if (hist[i] == int'(m_lvl)) all = 0;
            m_rise = all && !m_lvl;
            m_fall = all && m_lvl;
            if (all) m_lvl = !m_lvl;
            for (int k = 0; k < 2; k++) begin
                c = m_cnt[k];
                set = 0;
                if (inc) begin
                    if (c == mx[k]) set = 1;
                    else c++;
                end
                if (!m_vld && snap) begin m_data[k] = c; m_cnt[k] = 0; m_ovf[k] = 0; end
                else begin m_cnt[k] = c; m_ovf[k] = m_ovf[k] | set; end
            end
            if (!m_vld && snap) m_vld = 1;
            else if (m_vld && rdy) m_vld = 0;
        end
        #1;
    endtask

    task automatic pulse();
        en = 1; snap = 0; rdy = 0;
        din = 1; repeat (4) step();
        din = 0; repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1; din = 1; en = 1; snap = 1; rdy = 1;
        step(); step();
        vectors++;
        if ({level, rise, fall, b8.cnt_vld, b8.cnt_data, ovf} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset: got %h expected 000", {level, rise, fall, b8.cnt_vld, b8.cnt_data, ovf});
        end
        rst = 0; din = 0; snap = 0; rdy = 0;
    endtask

    task automatic test_filter();
        int nr = 0, nf = 0;
        en = 1; din = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            nr += int'(rise);
            if (i == 2) begin
                vectors++;
                if (level !== 1'b1 || rise !== 1'b1) begin
                    miscompares++;
                    $display("FAIL filter_rise: level=%b rise=%b expected 1 1", level, rise);
                end
            end
        end
        vectors++;
        if (nr != 1) begin miscompares++; $display("FAIL rise_width: got %0d cycles expected 1", nr); end
        din = 0;
        nr = 0;
        for (int i = 0; i < 4; i++) begin step(); nf += int'(fall); nr += int'(rise); end
        vectors++;
        if (nf != 1 || nr != 0 || level !== 1'b0) begin
            miscompares++;
            $display("FAIL filter_fall: falls=%0d rises=%0d level=%b expected 1 0 0", nf, nr, level);
        end
        nf = 0;
        din = 1; repeat (2) begin step(); nr += int'(rise); nf += int'(fall); end
        din = 0; repeat (3) begin step(); nr += int'(rise); nf += int'(fall); end
        vectors++;
        if (nr != 0 || nf != 0 || level !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch: rises=%0d falls=%0d level=%b expected 0 0 0", nr, nf, level);
        end
    endtask

    task automatic test_snapshot();
        repeat (3) pulse();
        vectors++;
        if (ovf2 !== 1'b1) begin miscompares++; $display("FAIL ovf_small: got %b expected 1", ovf2); end
        snap = 1; step(); snap = 0;
        vectors++;
        if (b8.cnt_vld !== 1'b1 || b8.cnt_data !== 8'd4 || b2.cnt_data !== 2'd3 || ovf2 !== 1'b0) begin
            miscompares++;
            $display("FAIL snap4: vld=%b data=%0d data2=%0d ovf2=%b expected 1 4 3 0",
                     b8.cnt_vld, b8.cnt_data, b2.cnt_data, ovf2);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (b8.cnt_vld !== 1'b1 || b8.cnt_data !== 8'd4) begin
                miscompares++;
                $display("FAIL hold%0d: vld=%b data=%0d expected 1 4", i, b8.cnt_vld, b8.cnt_data);
            end
        end
        snap = 1; step(); snap = 0;
        vectors++;
        if (b8.cnt_data !== 8'd4) begin miscompares++; $display("FAIL snap_in_hold: data=%0d expected 4", b8.cnt_data); end
        rdy = 1; step(); rdy = 0;
        vectors++;
        if (b8.cnt_vld !== 1'b0) begin miscompares++; $display("FAIL release: vld=%b expected 0", b8.cnt_vld); end
        snap = 1; step(); snap = 0;
        vectors++;
        if (b8.cnt_data !== 8'd0) begin miscompares++; $display("FAIL cleared: data=%0d expected 0", b8.cnt_data); end
        rdy = 1; step(); rdy = 0;
    endtask

    task automatic test_saturation();
        repeat (5) pulse();
        vectors++;
        if (ovf2 !== 1'b1 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_ovf: ovf2=%b ovf=%b expected 1 0", ovf2, ovf);
        end
        snap = 1; step(); snap = 0;
        vectors++;
        if (b2.cnt_data !== 2'd3 || b8.cnt_data !== 8'd5 || ovf2 !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_snap: data2=%0d data=%0d ovf2=%b expected 3 5 0", b2.cnt_data, b8.cnt_data, ovf2);
        end
        rdy = 1; step(); rdy = 0;
    endtask

    task automatic test_snap_with_rise();
        repeat (2) pulse();
        din = 1; repeat (3) step();
        snap = 1; step(); snap = 0;
        vectors++;
        if (b8.cnt_data !== 8'd3) begin miscompares++; $display("FAIL snap_rise: data=%0d expected 3", b8.cnt_data); end
        rdy = 1; din = 0; repeat (4) step();
        snap = 1; step(); snap = 0;
        vectors++;
        if (b8.cnt_data !== 8'd0) begin miscompares++; $display("FAIL snap_rise_clear: data=%0d expected 0", b8.cnt_data); end
        step(); rdy = 0;
    endtask

    task automatic test_reset_in_hold();
        repeat (2) pulse();
        snap = 1; step(); snap = 0;
        vectors++;
        if (b8.cnt_vld !== 1'b1 || b8.cnt_data !== 8'd2) begin
            miscompares++;
            $display("FAIL hold2: vld=%b data=%0d expected 1 2", b8.cnt_vld, b8.cnt_data);
        end
        din = 1; repeat (2) step();
        rst = 1; step(); rst = 0;
        vectors++;
        if ({level, rise, fall, b8.cnt_vld, b8.cnt_data} !== 12'h0) begin
            miscompares++;
            $display("FAIL rst_hold: got %h expected 000", {level, rise, fall, b8.cnt_vld, b8.cnt_data});
        end
        en = 0; step(); step();
        vectors++;
        if (level !== 1'b0 || rise !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_filter: level=%b rise=%b expected 0 0", level, rise);
        end
        step();
        vectors++;
        if (level !== 1'b1 || rise !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst_rise: level=%b rise=%b expected 1 1", level, rise);
        end
        din = 0; repeat (4) step();
        snap = 1; step(); snap = 0;
        vectors++;
        if (b8.cnt_data !== 8'd0) begin miscompares++; $display("FAIL rst_cnt: data=%0d expected 0", b8.cnt_data); end
        rdy = 1; step(); rdy = 0;
    endtask

    task automatic test_random();
        logic [19:0] act, exp;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) din = ~din;
            en   = ($urandom_range(3) != 0);
            snap = ($urandom_range(7) == 0);
            rdy  = ($urandom_range(2) == 0);
            rst  = ($urandom_range(199) == 0);
            step();
            act = {level, rise, fall, b8.cnt_vld, b8.cnt_data, ovf,
                   level2, rise2, fall2, b2.cnt_vld, b2.cnt_data, ovf2};
            exp = {m_lvl, m_rise, m_fall, m_vld, 8'(m_data[0]), m_ovf[0],
                   m_lvl, m_rise, m_fall, m_vld, 2'(m_data[1]), m_ovf[1]};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %h expected %h", i, act, exp);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_filter();
        test_snapshot();
        test_saturation();
        test_snap_with_rise();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
